// File: rtl/serial_addsub_seq_if.sv
// Handshake bundle for serial_addsub_seq.
//   master: operand producer / result consumer
//     (drives in_valid, a, b, m, out_ready)
//   slave : the add/sub unit
//     (drives in_ready, out_valid, s, cout, v)
interface serial_addsub_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             v;

  modport master (
    output in_valid, a, b, m, out_ready,
    input  in_ready, out_valid, s, cout, v
  );

  modport slave (
    input  in_valid, a, b, m, out_ready,
    output in_ready, out_valid, s, cout, v
  );
endinterface

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract unit. Computes A+B (m=0) or A-B (m=1) LSB-first
// through a single full-adder slice, one bit per clock.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   bus      : slave side of serial_addsub_seq_if
//              in_valid/in_ready  operand handshake (a, b, m)
//              out_valid/out_ready result handshake (s, cout, v)
// An operation accepted at edge T presents its result after edge T+WIDTH.
module serial_addsub_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic               clk,
  input logic               rst,
  serial_addsub_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;
  logic [WIDTH-1:0] s_q;
  logic             carry;
  logic             cout_q;
  logic             v_q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last;
  logic             sum_bit;
  logic             carry_next;

  assign accept = bus.in_valid && (state == IDLE);

  // Operands are shifted right each BUSY cycle, so bit 0 always holds bit cnt.
  always_comb begin
    sum_bit    = a_q[0] ^ bx_q[0] ^ carry;
    carry_next = (a_q[0] & bx_q[0]) | (a_q[0] & carry) | (bx_q[0] & carry);
    last       = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      bx_q   <= '0;
      s_q    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtract as A + ~B + 1: invert B here, inject the +1 as carry-in.
            a_q   <= bus.a;
            bx_q  <= bus.b ^ {WIDTH{bus.m}};
            carry <= bus.m;
            cnt   <= '0;
          end
        end
        BUSY: begin
          a_q   <= a_q >> 1;
          bx_q  <= bx_q >> 1;
          s_q   <= {sum_bit, s_q[WIDTH-1:1]};
          carry <= carry_next;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            cout_q <= carry_next;
            v_q    <= carry ^ carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.v         = v_q;

endmodule
